// File: rtl/edge_gen.sv
// edge_gen: turns single-cycle rise/fall requests into clean d_out transitions,
// each level held at least MIN_HOLD cycles. Define EDGE_GEN_ECHO_EN for rise_edge/fall_edge strobes.
module edge_gen #(
  parameter int unsigned MIN_HOLD = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rise_req,
  input  logic             fall_req,
  output logic             d_out,
  output logic             busy,
  output logic             pending,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_cnt
`ifdef EDGE_GEN_ECHO_EN
  ,
  output logic             rise_edge,
  output logic             fall_edge
`endif
);

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    HOLD_HIGH = 2'd1,
    HIGH      = 2'd2,
    HOLD_LOW  = 2'd3
  } state_t;

  localparam logic [7:0]       HOLD_LOAD = 8'(MIN_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state;
  logic [7:0] hold_cnt;
  logic       both, opp, same, in_hold, live, expired, flip, settle, drop, pending_nxt;

  // Request classification relative to the current level, plus transition decisions
  always_comb begin
    both    = rise_req & fall_req;
    opp     = d_out ? (fall_req & ~rise_req) : (rise_req & ~fall_req);
    same    = d_out ? (rise_req & ~fall_req) : (fall_req & ~rise_req);
    in_hold = (state == HOLD_HIGH) || (state == HOLD_LOW);
    live    = in_hold && (hold_cnt != 8'd0);
    expired = in_hold && (hold_cnt == 8'd0);
    flip    = (!in_hold && opp) || (expired && (pending || opp));
    settle  = expired && !flip;
    drop    = both || (live && pending && opp);
    pending_nxt = pending;
    if (expired && pending) begin
      // After the buffered flip, a request matching the old level opposes the new one
      pending_nxt = same;
    end else if (live && opp) begin
      pending_nxt = 1'b1;
    end else if (live && same) begin
      pending_nxt = 1'b0;
    end else begin
      pending_nxt = pending;
    end
  end

  // Level/hold state machine with registered outputs and drop accounting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= LOW;
      hold_cnt <= 8'd0;
      d_out    <= 1'b0;
      busy     <= 1'b0;
      pending  <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= {CNT_W{1'b0}};
    end else begin
      if (flip) begin
        state    <= d_out ? HOLD_LOW : HOLD_HIGH;
        d_out    <= ~d_out;
        busy     <= 1'b1;
        hold_cnt <= HOLD_LOAD;
      end else if (settle) begin
        state <= d_out ? HIGH : LOW;
        busy  <= 1'b0;
      end else if (live) begin
        hold_cnt <= hold_cnt - 8'd1;
      end else begin
        hold_cnt <= hold_cnt;
      end
      pending <= pending_nxt;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != CNT_MAX) begin
          drop_cnt <= drop_cnt + CNT_ONE;
        end else begin
          drop_cnt <= drop_cnt;
        end
      end else begin
        drop_cnt <= drop_cnt;
      end
    end
  end

`ifdef EDGE_GEN_ECHO_EN
  // Strobes coincide with the first cycle d_out shows its new level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_edge <= 1'b0;
      fall_edge <= 1'b0;
    end else begin
      rise_edge <= flip && !d_out;
      fall_edge <= flip && d_out;
    end
  end
`endif

endmodule

// File: tb/tb_edge_gen.sv
// Self-checking bench for edge_gen: directed scenarios plus randomized requests
// compared against a level/age based reference model.
module tb_edge_gen;
  localparam int MIN_HOLD = 4;
  localparam int CNT_W    = 8;
  localparam int CNT_SAT  = (1 << CNT_W) - 1;
`ifdef EDGE_GEN_ECHO_EN
  localparam int EW = 4 + CNT_W + 2;
`else
  localparam int EW = 4 + CNT_W;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rise_req = 1'b0;
  logic fall_req = 1'b0;
  logic d_out, busy, pending, overflow;
  logic [CNT_W-1:0] drop_cnt;
  logic [EW-1:0] dut_vec;
`ifdef EDGE_GEN_ECHO_EN
  logic rise_edge, fall_edge;
  assign dut_vec = {d_out, busy, pending, overflow, drop_cnt, rise_edge, fall_edge};
`else
  assign dut_vec = {d_out, busy, pending, overflow, drop_cnt};
`endif

  edge_gen #(.MIN_HOLD(MIN_HOLD), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .rise_req(rise_req), .fall_req(fall_req),
    .d_out(d_out), .busy(busy), .pending(pending), .overflow(overflow),
    .drop_cnt(drop_cnt)
`ifdef EDGE_GEN_ECHO_EN
    , .rise_edge(rise_edge), .fall_edge(fall_edge)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int fails   = 0;

  // Reference model: current level, cycles spent at it, buffered flag, drop total
  bit m_level, m_busy, m_pend, m_ovf, m_re, m_fe;
  int m_age, m_drops;

  function automatic void model_reset();
    m_level = 1'b0; m_busy = 1'b0; m_pend = 1'b0; m_ovf = 1'b0;
    m_re = 1'b0; m_fe = 1'b0; m_age = 0; m_drops = 0;
  endfunction

  function automatic void model_step(input bit r, input bit f);
    bit want_v, want, flipped, exp;
    want_v = r ^ f;
    want = r;
    flipped = 1'b0;
    if (r && f) begin m_drops++; m_ovf = 1'b1; end
    exp = m_busy && (m_age >= MIN_HOLD);
    if (!m_busy || exp) begin
      if (exp && m_pend) begin
        m_level = !m_level;
        flipped = 1'b1;
        m_pend = want_v && (want != m_level);
      end else if (want_v && (want != m_level)) begin
        m_level = want;
        flipped = 1'b1;
        m_pend = 1'b0;
      end else begin
        m_busy = 1'b0;
      end
    end else begin
      m_age++;
      if (want_v && (want != m_level)) begin
        if (m_pend) begin m_drops++; m_ovf = 1'b1; end
        else m_pend = 1'b1;
      end else if (want_v) begin
        m_pend = 1'b0;
      end
    end
    m_re = flipped && m_level;
    m_fe = flipped && !m_level;
    if (flipped) begin m_busy = 1'b1; m_age = 1; end
  endfunction

  function automatic logic [EW-1:0] model_vec();
    logic [CNT_W-1:0] dc;
    dc = (m_drops >= CNT_SAT) ? CNT_W'(CNT_SAT) : CNT_W'(m_drops);
`ifdef EDGE_GEN_ECHO_EN
    return {m_level, m_busy, m_pend, m_ovf, dc, m_re, m_fe};
`else
    return {m_level, m_busy, m_pend, m_ovf, dc};
`endif
  endfunction

  task automatic do_reset();
    rise_req = 1'b0; fall_req = 1'b0; rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic cycle(input bit r, input bit f);
    @(negedge clk);
    rise_req = r; fall_req = f;
    @(posedge clk);
    model_step(r, f);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (dut_vec !== {EW{1'b0}}) begin
      fails++; $display("FAIL reset: got %h want %h", dut_vec, {EW{1'b0}});
    end
  endtask

  task automatic test_single_rise();
    logic [11:0] rs;
    rs = 12'b0000_0000_0100;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cycle(rs[i], 1'b0);
      vectors++;
      if (dut_vec !== model_vec()) begin
        fails++; $display("FAIL single_rise c%0d: got %h want %h", i, dut_vec, model_vec());
      end
    end
    vectors++;
    if ({d_out, busy, pending} !== 3'b100) begin
      fails++; $display("FAIL single_rise_end: got %b want 100", {d_out, busy, pending});
    end
  endtask

  task automatic test_pending_fall();
    logic [13:0] rs, fs;
    int high_cycles;
    rs = 14'b00_0000_0000_0100;
    fs = 14'b00_0000_0001_0000;
    high_cycles = 0;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      cycle(rs[i], fs[i]);
      if (d_out === 1'b1) high_cycles++;
      vectors++;
      if (dut_vec !== model_vec()) begin
        fails++; $display("FAIL pending_fall c%0d: got %h want %h", i, dut_vec, model_vec());
      end
    end
    vectors++;
    if (high_cycles != MIN_HOLD) begin
      fails++; $display("FAIL pending_fall_width: got %0d want %0d", high_cycles, MIN_HOLD);
    end
  endtask

  task automatic test_drop();
    logic [13:0] rs, fs;
    int falls;
    logic prev;
    rs = 14'b00_0000_0000_0100;
    fs = 14'b00_0000_0001_1000;
    falls = 0;
    do_reset();
    prev = d_out;
    for (int i = 0; i < 14; i++) begin
      cycle(rs[i], fs[i]);
      if (prev === 1'b1 && d_out === 1'b0) falls++;
      prev = d_out;
      vectors++;
      if (dut_vec !== model_vec()) begin
        fails++; $display("FAIL drop c%0d: got %h want %h", i, dut_vec, model_vec());
      end
    end
    vectors++;
    if ({overflow, drop_cnt} !== {1'b1, 8'd1} || falls != 1) begin
      fails++; $display("FAIL drop_end: got ovf=%b cnt=%0d falls=%0d want 1/1/1", overflow, drop_cnt, falls);
    end
  endtask

  task automatic test_cancel();
    logic [11:0] rs, fs;
    rs = 12'b0000_0001_0100;
    fs = 12'b0000_0000_1000;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cycle(rs[i], fs[i]);
      vectors++;
      if (dut_vec !== model_vec()) begin
        fails++; $display("FAIL cancel c%0d: got %h want %h", i, dut_vec, model_vec());
      end
    end
    vectors++;
    if ({d_out, pending, overflow, drop_cnt} !== {3'b100, 8'd0}) begin
      fails++; $display("FAIL cancel_end: got d=%b p=%b ovf=%b cnt=%0d want 1/0/0/0", d_out, pending, overflow, drop_cnt);
    end
  endtask

  task automatic test_both_saturate();
    do_reset();
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b1);
    vectors++;
    if ({d_out, overflow, drop_cnt} !== {2'b01, 8'd1} || dut_vec !== model_vec()) begin
      fails++; $display("FAIL both_once: got %h want %h", dut_vec, model_vec());
    end
    for (int i = 0; i < 300; i++) cycle(1'b1, 1'b1);
    vectors++;
    if (drop_cnt !== 8'd255 || overflow !== 1'b1 || d_out !== 1'b0) begin
      fails++; $display("FAIL both_saturate: got cnt=%0d ovf=%b d=%b want 255/1/0", drop_cnt, overflow, d_out);
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] rs, fs;
    rs = 5'b00100;
    fs = 5'b01000;
    do_reset();
    for (int i = 0; i < 5; i++) cycle(rs[i], fs[i]);
    vectors++;
    if ({d_out, busy, pending} !== 3'b111 || dut_vec !== model_vec()) begin
      fails++; $display("FAIL async_pre: got %h want %h", dut_vec, model_vec());
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (dut_vec !== {EW{1'b0}}) begin
      fails++; $display("FAIL async_reset: got %h want %h", dut_vec, {EW{1'b0}});
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 7; i++) begin
      cycle(i == 0, 1'b0);
      vectors++;
      if (dut_vec !== model_vec()) begin
        fails++; $display("FAIL async_after c%0d: got %h want %h", i, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 24; i++) begin
      cycle(i[0] == 1'b0, i[0] == 1'b1);
      vectors++;
      if (dut_vec !== model_vec()) begin
        fails++; $display("FAIL back_to_back c%0d: got %h want %h", i, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_random();
    bit r, f;
    int run;
    logic prev;
    do_reset();
    run = MIN_HOLD;
    prev = d_out;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 9) < 3);
      f = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 15) == 0) begin r = 1'b1; f = 1'b1; end
      cycle(r, f);
      vectors++;
      if (dut_vec !== model_vec()) begin
        fails++; $display("FAIL random c%0d: got %h want %h", i, dut_vec, model_vec());
      end
      if (d_out !== prev) begin
        vectors++;
        if (run < MIN_HOLD) begin
          fails++; $display("FAIL random_hold c%0d: got %0d want >=%0d", i, run, MIN_HOLD);
        end
        run = 1;
        prev = d_out;
      end else begin
        run++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_rise();
    test_pending_fall();
    test_drop();
    test_cancel();
    test_both_saturate();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
